key_debounce_array: RTL and testbench

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_array_if.sv | 22 ++
 rtl/key_debounce_chan.sv | 139 +++++++++++++
 rtl/key_debounce_array.sv | 42 ++++
 tb/tb_key_debounce_array.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the key debounce array.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } key_state_e;

    // Bits needed to hold 0..max_count; never less than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Button pins in, debounced levels and event pulses out.
interface key_debounce_array_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] button_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output button_in, repeat_en,
        input  level_out, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  button_in, repeat_en,
        output level_out, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_debounce_chan.sv
// One button channel: synchronizer, stable-count filter and press/hold/repeat FSM.
// state       | meaning
// ST_RELEASED | debounced level low, waiting for an accepted press
// ST_PRESSED  | pressed, hold counter running toward the long-press event
// ST_HELD     | long-press fired, repeat counter running
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic button_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam int REP_W  = cnt_width(REPEAT_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic RELEASED_RAW = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    logic              sync1_q, sync2_q, sample;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    key_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              press_q, press_d, release_q, release_d;
    logic              long_q, long_d, repeat_q, repeat_d;

    assign sample = (ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q    <= RELEASED_RAW;
            sync2_q    <= RELEASED_RAW;
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            state_q    <= ST_RELEASED;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync1_q    <= button_i;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    // Toggle and clear on the same edge the last differing sample arrives.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sample != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (level_d) begin
                    state_d    = ST_PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (!level_d) begin
                    state_d    = ST_RELEASED;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_HELD;
                    long_d     = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_HELD: begin
                // A release on the repeat boundary swallows that repeat.
                if (!level_d) begin
                    state_d    = ST_RELEASED;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = '0;
                    repeat_d  = repeat_en_i;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// N_CH independent debounce channels; this level only distributes pins.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_HIGH     = 1
) (
    input logic                 clk_in,
    input logic                 reset,
    key_debounce_array_if.slave kbus
);
    logic [N_CH-1:0] level_w, press_w, release_w, long_w, repeat_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_HIGH     (ACTIVE_HIGH)
        ) u_chan (
            .clk_in      (clk_in),
            .reset       (reset),
            .button_i    (kbus.button_in[i]),
            .repeat_en_i (kbus.repeat_en[i]),
            .level_o     (level_w[i]),
            .press_o     (press_w[i]),
            .release_o   (release_w[i]),
            .long_o      (long_w[i]),
            .repeat_o    (repeat_w[i])
        );
    end

    assign kbus.level_out     = level_w;
    assign kbus.press_pulse   = press_w;
    assign kbus.release_pulse = release_w;
    assign kbus.long_pulse    = long_w;
    assign kbus.repeat_pulse  = repeat_w;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed scenarios then random button traffic against an elapsed-time model.
module tb_key_debounce_array;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int H  = 20;
    localparam int R  = 5;
    localparam int AH = 1;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    key_debounce_array_if #(.N_CH(N)) kbus ();

    key_debounce_array #(
        .N_CH(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
        .REPEAT_CYCLES(R), .ACTIVE_HIGH(AH)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .kbus   (kbus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: delayed samples, run lengths, time since press.
    logic [N-1:0] m_s1, m_s2, m_lvl;
    int           m_run [N];
    int           m_el  [N];
    logic [N-1:0] e_press, e_rel, e_long, e_rep;

    // Observed event statistics for scenario-level checks.
    int n_press [N];
    int n_rel   [N];
    int n_long  [N];
    int n_rep   [N];
    int n_lvl   [N];
    int press_at[N];
    int n_1001;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
            n_rep[i] = 0; n_lvl[i] = 0; press_at[i] = -1;
        end
        n_1001 = 0;
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic [N-1:0] en, input logic r);
        logic [N-1:0] nb;
        logic         filt;
        logic         was;
        nb = (AH != 0) ? b : ~b;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            for (int i = 0; i < N; i++) begin m_run[i] = 0; m_el[i] = -1; end
        end else begin
            for (int i = 0; i < N; i++) begin
                filt    = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = nb[i];
                was     = m_lvl[i];
                if (filt != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_lvl[i] && !was) begin
                    e_press[i] = 1'b1;
                    m_el[i]    = 0;
                end else if (!m_lvl[i] && was) begin
                    e_rel[i] = 1'b1;
                    m_el[i]  = -1;
                end else if (m_el[i] >= 0) begin
                    m_el[i]++;
                    if (m_el[i] == H)
                        e_long[i] = 1'b1;
                    else if (m_el[i] > H && ((m_el[i] - H) % R) == 0 && en[i])
                        e_rep[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] b, input logic [N-1:0] en, input logic r);
        cyc++;
        kbus.button_in = b;
        kbus.repeat_en = en;
        reset          = r;
        @(posedge clk_in);
        model_step(b, en, r);
        #1;
        chk("level_out",     kbus.level_out,     m_lvl);
        chk("press_pulse",   kbus.press_pulse,   e_press);
        chk("release_pulse", kbus.release_pulse, e_rel);
        chk("long_pulse",    kbus.long_pulse,    e_long);
        chk("repeat_pulse",  kbus.repeat_pulse,  e_rep);
        for (int i = 0; i < N; i++) begin
            n_press[i] += int'(kbus.press_pulse[i]);
            n_rel[i]   += int'(kbus.release_pulse[i]);
            n_long[i]  += int'(kbus.long_pulse[i]);
            n_rep[i]   += int'(kbus.repeat_pulse[i]);
            n_lvl[i]   += int'(kbus.level_out[i]);
            if (kbus.press_pulse[i] && press_at[i] < 0) press_at[i] = cyc;
        end
        if (kbus.press_pulse == 4'b1001) n_1001++;
    endtask

    initial begin
        int c0;
        int rst_last;
        logic [N-1:0] base, glitch, ren;
        logic         rr;

        kbus.button_in = '0;
        kbus.repeat_en = '0;
        clear_stats();
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) cycle(4'b0000, 4'b0000, 1'b0);

        // Single press on ch0: accepted 5 edges after the pin rises.
        clear_stats();
        c0 = cyc + 1;
        for (int i = 0; i < 20; i++) cycle(4'b0001, 4'b0000, 1'b0);
        chk_int("ch0_press_count", n_press[0], 1);
        chk_int("ch0_press_cycle", press_at[0], c0 + 5);
        chk_int("others_press_count", n_press[1] + n_press[2] + n_press[3], 0);
        for (int i = 0; i < 20; i++) cycle(4'b0000, 4'b0000, 1'b0);

        // Short bounce on ch1 must be invisible.
        clear_stats();
        cycle(4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b0);
        cycle(4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 15; i++) cycle(4'b0000, 4'b0000, 1'b0);
        chk_int("ch1_bounce_events", n_press[1] + n_rel[1] + n_long[1] + n_rep[1], 0);
        chk_int("ch1_bounce_level", n_lvl[1], 0);

        // Long hold on ch2 with repeat; release lands on a repeat boundary.
        clear_stats();
        for (int i = 0; i < 45; i++) cycle(4'b0100, 4'b0100, 1'b0);
        for (int i = 0; i < 15; i++) cycle(4'b0000, 4'b0100, 1'b0);
        chk_int("ch2_long_count",   n_long[2], 1);
        chk_int("ch2_repeat_count", n_rep[2],  4);
        chk_int("ch2_release_count", n_rel[2], 1);

        // Same hold with repeat disabled.
        clear_stats();
        for (int i = 0; i < 45; i++) cycle(4'b0100, 4'b0000, 1'b0);
        for (int i = 0; i < 15; i++) cycle(4'b0000, 4'b0000, 1'b0);
        chk_int("ch2_norep_long",   n_long[2], 1);
        chk_int("ch2_norep_repeat", n_rep[2],  0);

        // Simultaneous press on ch0 and ch3.
        clear_stats();
        for (int i = 0; i < 15; i++) cycle(4'b1001, 4'b0000, 1'b0);
        for (int i = 0; i < 15; i++) cycle(4'b0000, 4'b0000, 1'b0);
        chk_int("press_1001_cycles", n_1001, 1);

        // Reset while ch0 is held: no release, fresh press 6 edges later.
        for (int i = 0; i < 40; i++) cycle(4'b0001, 4'b0000, 1'b0);
        clear_stats();
        for (int i = 0; i < 3; i++) cycle(4'b0001, 4'b0000, 1'b1);
        rst_last = cyc;
        for (int i = 0; i < 10; i++) cycle(4'b0001, 4'b0000, 1'b0);
        chk_int("rst_no_release", n_rel[0], 0);
        chk_int("rst_repress_cycle", press_at[0], rst_last + 6);
        for (int i = 0; i < 15; i++) cycle(4'b0000, 4'b0000, 1'b0);

        // Random traffic: slow level changes, one-cycle glitches, rare resets.
        base = '0;
        ren  = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) base[i] = ~base[i];
                glitch[i] = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 63) == 0) ren[i] = ~ren[i];
            end
            rr = ($urandom_range(0, 499) == 0);
            cycle(base ^ glitch, ren, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
